regfile_ctx: RTL and testbench



---
 rtl/regfile_ctx.sv | 157 +++++++++++++++
 tb/tb_regfile_ctx.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_ctx.sv
// Parametrised register file with write-to-read bypass and a serial
// context save/restore engine driven by the interrupt controller.
module regfile_ctx #(
    parameter int                DATA_W     = 16,
    parameter int                ADDR_W     = 4,
    parameter int                ZERO_IDX   = 15,
    parameter int                SP_IDX     = 14,
    parameter int                RESULT_IDX = 0,
    parameter logic [DATA_W-1:0] SP_INIT    = 16'hFFFE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic [DATA_W-1:0] result_reg,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              save_start,
    input  logic              restore_start,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] save_data,
    output logic [ADDR_W-1:0] save_idx,
    output logic              save_valid,
    input  logic              save_ready,
    input  logic [DATA_W-1:0] restore_data,
    input  logic              restore_valid,
    output logic              restore_ready
);

    localparam int NREGS = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZI = ADDR_W'(ZERO_IDX);
    localparam logic [ADDR_W-1:0] RI = ADDR_W'(RESULT_IDX);
    localparam logic [ADDR_W-1:0] FIRST_IDX =
        (ZERO_IDX == 0) ? ADDR_W'(1) : ADDR_W'(0);
    localparam logic [ADDR_W-1:0] LAST_IDX =
        (ZERO_IDX == NREGS - 1) ? ADDR_W'(NREGS - 2) : ADDR_W'(NREGS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SAVE,
        RESTORE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] mem_q [NREGS];
    logic              core_we;
    logic              rst_we;
    logic              idle;

    function automatic logic [ADDR_W-1:0] step(input logic [ADDR_W-1:0] i);
        logic [ADDR_W-1:0] n;
        n = i + ADDR_W'(1);
        if (n == ZI) n = n + ADDR_W'(1);
        return n;
    endfunction

    assign idle    = (state_q == IDLE);
    assign core_we = wr_en && idle && (wr_addr != ZI);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        rst_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (save_start) begin
                    state_d = SAVE;
                    idx_d   = FIRST_IDX;
                end else if (restore_start) begin
                    state_d = RESTORE;
                    idx_d   = FIRST_IDX;
                end
            end
            SAVE: begin
                if (save_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = step(idx_q);
                    end
                end
            end
            RESTORE: begin
                if (restore_valid) begin
                    rst_we = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = step(idx_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    // Core writes and restore writes are mutually exclusive via busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= (i == SP_IDX) ? SP_INIT : '0;
            end
        end else if (core_we) begin
            mem_q[wr_addr] <= wr_data;
        end else if (rst_we && (idx_q != ZI)) begin
            mem_q[idx_q] <= restore_data;
        end
    end

    always_comb begin
        if (rd_addr1 == ZI)
            rd_data1 = '0;
        else if (wr_en && idle && (wr_addr == rd_addr1))
            rd_data1 = wr_data;
        else
            rd_data1 = mem_q[rd_addr1];
    end

    always_comb begin
        if (rd_addr2 == ZI)
            rd_data2 = '0;
        else if (wr_en && idle && (wr_addr == rd_addr2))
            rd_data2 = wr_data;
        else
            rd_data2 = mem_q[rd_addr2];
    end

    assign result_reg    = (RI == ZI) ? '0 : mem_q[RI];
    assign busy          = !idle;
    assign done          = done_q;
    assign save_valid    = (state_q == SAVE);
    assign save_idx      = save_valid ? idx_q : '0;
    assign save_data     = save_valid ? mem_q[idx_q] : '0;
    assign restore_ready = (state_q == RESTORE);

endmodule

// File: tb/tb_regfile_ctx.sv
// Directed bench for regfile_ctx: reads, bypass, save/restore streams,
// back-pressure, start arbitration and asynchronous reset.
module tb_regfile_ctx;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  rd_addr1, rd_addr2;
    logic [15:0] rd_data1, rd_data2, result_reg;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        save_start, restore_start;
    logic        busy, done;
    logic [15:0] save_data;
    logic [3:0]  save_idx;
    logic        save_valid, save_ready;
    logic [15:0] restore_data;
    logic        restore_valid, restore_ready;

    typedef struct packed {
        logic [3:0]  idx;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   tests = 0;
    int   fails = 0;

    regfile_ctx dut (
        .clk(clk), .reset(reset),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .result_reg(result_reg),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .save_start(save_start), .restore_start(restore_start),
        .busy(busy), .done(done),
        .save_data(save_data), .save_idx(save_idx),
        .save_valid(save_valid), .save_ready(save_ready),
        .restore_data(restore_data), .restore_valid(restore_valid),
        .restore_ready(restore_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int n, cyc, stall;
        reset = 1'b1;
        rd_addr1 = '0; rd_addr2 = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        save_start = 1'b0; restore_start = 1'b0;
        save_ready = 1'b0; restore_valid = 1'b0; restore_data = '0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sv", save_valid, 0);
        chk("rst_rr", restore_ready, 0);
        chk("rst_sdata", save_data, 0);
        chk("rst_sidx", save_idx, 0);
        chk("rst_result", result_reg, 0);
        for (int i = 0; i < 16; i++) begin
            rd_addr1 = 4'(i);
            rd_addr2 = 4'(15 - i);
            #1;
            chk("rst_rd1", rd_data1, (i == 14) ? 16'hFFFE : 16'h0);
            chk("rst_rd2", rd_data2, (i == 1) ? 16'hFFFE : 16'h0);
        end
        #1 reset = 1'b0;

        tick();
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hA5A5; rd_addr1 = 4'd3;
        #1 chk("bypass", rd_data1, 16'hA5A5);
        tick();
        wr_en = 1'b0;
        #1 chk("stored", rd_data1, 16'hA5A5);
        wr_en = 1'b1; wr_addr = 4'd15; wr_data = 16'h1234; rd_addr2 = 4'd15;
        #1 chk("zero_byp", rd_data2, 0);
        tick();
        wr_en = 1'b0;
        #1 chk("zero_st", rd_data2, 0);

        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_addr = 4'(i); wr_data = 16'h0100 + 16'(i);
            if (i != 15) sb.push_back({4'(i), 16'h0100 + 16'(i)});
            tick();
        end
        wr_en = 1'b0;
        #1 chk("result_reg", result_reg, 16'h0100);

        save_start = 1'b1; save_ready = 1'b1;
        tick();
        save_start = 1'b0;
        chk("s1_busy", busy, 1);
        chk("s1_valid", save_valid, 1);
        n = 0; cyc = 0;
        while (n < 15 && cyc < 40) begin
            if (save_valid) begin
                e = sb.pop_front();
                chk("s1_idx", save_idx, e.idx);
                chk("s1_data", save_data, e.data);
                n++;
            end
            chk("s1_nodone", done, 0);
            tick();
            cyc++;
        end
        chk("s1_count", n, 15);
        chk("s1_cycles", cyc, 15);
        chk("s1_done", done, 1);
        chk("s1_idle", busy, 0);
        tick();
        chk("s1_done1", done, 0);

        for (int i = 0; i < 15; i++)
            sb.push_back({4'(i), 16'h0100 + 16'(i)});
        save_start = 1'b1;
        tick();
        save_start = 1'b0;
        n = 0; cyc = 0; stall = 0;
        while (n < 15 && cyc < 60) begin
            if (save_valid && save_idx == 4'd5 && stall < 3) begin
                save_ready = 1'b0;
                chk("bp_data", save_data, 16'h0105);
                chk("bp_idx", save_idx, 5);
                stall++;
            end else if (save_valid) begin
                save_ready = 1'b1;
                e = sb.pop_front();
                chk("bp_sidx", save_idx, e.idx);
                chk("bp_sdata", save_data, e.data);
                n++;
            end
            tick();
            cyc++;
        end
        chk("bp_stalls", stall, 3);
        chk("bp_cycles", cyc, 18);
        chk("bp_done", done, 1);
        chk("bp_sb", sb.size(), 0);

        save_ready = 1'b0;
        for (int i = 0; i < 15; i++)
            sb.push_back({4'(i), 16'hF000 + 16'(i)});
        restore_start = 1'b1;
        tick();
        restore_start = 1'b0;
        chk("r_busy", busy, 1);
        n = 0; cyc = 0; stall = 0;
        while (n < 15 && cyc < 40) begin
            chk("r_ready", restore_ready, 1);
            wr_en = (n == 8);
            wr_addr = 4'd2; wr_data = 16'hDEAD; rd_addr1 = 4'd2;
            if (n == 4 && stall == 0) begin
                restore_valid = 1'b0;
                stall = 1;
                tick();
            end else begin
                restore_valid = 1'b1;
                restore_data = sb[0].data;
                if (n == 8) begin
                    #1 chk("r_nobyp", rd_data1, 16'hF002);
                end
                tick();
                void'(sb.pop_front());
                n++;
            end
            cyc++;
        end
        restore_valid = 1'b0; wr_en = 1'b0;
        chk("r_cycles", cyc, 16);
        chk("r_done", done, 1);
        chk("r_idle", busy, 0);
        for (int i = 0; i < 16; i++) begin
            rd_addr1 = 4'(i);
            #1 chk("r_reg", rd_data1, (i == 15) ? 16'h0 : 16'hF000 + 16'(i));
        end

        save_start = 1'b1; restore_start = 1'b1; save_ready = 1'b0;
        tick();
        save_start = 1'b0; restore_start = 1'b0;
        chk("both_sv", save_valid, 1);
        chk("both_rr", restore_ready, 0);
        save_ready = 1'b1;
        cyc = 0;
        while (!(save_valid && save_idx == 4'd7) && cyc < 20) begin
            chk("m_data", save_data, 16'hF000 + 16'(save_idx));
            tick();
            cyc++;
        end
        chk("m_reach7", save_idx, 7);
        reset = 1'b1; rd_addr2 = 4'd14;
        #1;
        chk("m_busy", busy, 0);
        chk("m_sv", save_valid, 0);
        chk("m_sp", rd_data2, 16'hFFFE);
        chk("m_sidx", save_idx, 0);
        #3 reset = 1'b0; save_ready = 1'b0;
        tick();
        chk("m_done", done, 0);
        chk("m_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
